// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file among NREQ requesters.
// Optional REGARB_LOCK_EN adds a lock input so one requester can own the file for atomic sequences.
module reg_file_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
`ifdef REGARB_LOCK_EN
  input  logic [NREQ-1:0]    lock_i,
`endif
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               rf_wr_en_o,
  output logic               rf_rd_en_o,
  output logic [AW-1:0]      rf_addr_o,
  output logic [DW-1:0]      rf_data_in_o,
  input  logic [DW-1:0]      rf_data_out_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic            rf_wr_q, rf_rd_q;
  logic [AW-1:0]   rf_addr_q;
  logic [DW-1:0]   rf_data_q;

  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [IW-1:0]   win_idx;

`ifdef REGARB_LOCK_EN
  logic            lock_q;
  logic            owner_vld_q;
  logic [IW-1:0]   owner_q;

  // An owner shuts out everyone else until it issues an unlocked access.
  always_comb begin
    elig = req_i;
    if (owner_vld_q) elig = req_i & (NREQ'(1) << owner_q);
  end
`else
  always_comb elig = req_i;
`endif

  // Scan downward so the candidate nearest the pointer is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[(int'(ptr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
`ifdef REGARB_LOCK_EN
      lock_q      <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rf_wr_q  <= 1'b0;
      rf_rd_q  <= 1'b0;
      case (state_q)
        IDLE: if (win_vld) begin
          idx_q     <= win_idx;
          we_q      <= we_i[win_idx];
          gnt_q     <= NREQ'(1) << win_idx;
          rf_wr_q   <= we_i[win_idx];
          rf_rd_q   <= !we_i[win_idx];
          rf_addr_q <= addr_i[int'(win_idx)*AW +: AW];
          rf_data_q <= wdata_i[int'(win_idx)*DW +: DW];
`ifdef REGARB_LOCK_EN
          lock_q    <= lock_i[win_idx];
`endif
        end
        ISSUE: begin
          ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          if (!we_q) rvalid_q <= gnt_q;
`ifdef REGARB_LOCK_EN
          owner_vld_q <= lock_q;
          owner_q     <= idx_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign rvalid_o     = rvalid_q;
  assign rf_wr_en_o   = rf_wr_q;
  assign rf_rd_en_o   = rf_rd_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_in_o = rf_data_q;
  // Regfile output is already registered; just gate it to zero outside the response cycle.
  assign rdata_o      = (rvalid_q != '0) ? rf_data_out_i : '0;

endmodule
